fir_out_decim: RTL and testbench
================================

# fir_out_decim

Output stage placed directly downstream of the FIR filter. It takes the filter's unsigned output samples, sums each block of `dec` consecutive samples, scales and saturates the sum, and buffers the results in a small FIFO. Results leave through a valid/ready handshake toward the next stage. Overflow of the FIFO is reported with a sticky flag.

## Interface
Parameters:
- IN_W, 11, width of the filter output sample `y_in` (unsigned)
- OUT_W, 8, width of `out_data` (unsigned)
- SHIFT, 2, right shift applied to the block sum before saturation (0..IN_W)
- DEPTH, 4, FIFO entries; must be a power of two, at least 2

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- y_in  input  IN_W  filter output sample
- y_valid  input  1  `y_in` is valid this cycle; no backpressure toward the filter
- dec  input  4  decimation factor, 1..15; 0 is treated as 1
- out_data  output  OUT_W  FIFO head; 0 while `out_valid` is 0
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts the head this cycle
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; set when a result is dropped because the FIFO is full

Clock `clk`, reset `rst`: one clock; reset is synchronous and active-high.

## Operation
- Phase counter `ph` (4 bits) and accumulator `acc` (IN_W+5 bits, unsigned).
- `dec_l` is latched from `dec` on the first accepted sample of a block (`ph`==0). A change to `dec` mid-block has no effect until the next block starts.
- Accepted sample (`y_valid`=1):
  - If it is not the last sample of the block: `acc` <= `acc`+`y_in`, and `ph` increments.
  - If it is the last sample (`ph`==`dec_l`-1, or the first sample when the latched factor is 1): form `s` = `acc`+`y_in`. Then compute r = `s` >> SHIFT. Saturate: if r > 2^OUT_W−1, the result is 2^OUT_W−1. The result is pushed to the FIFO. Then `acc` <= 0 and `ph` <= 0.
- Push and pop rules:
  - Push while FIFO full and no pop in the same cycle: the result is dropped, `overflow` <= 1, and FIFO contents are unchanged.
  - Push while FIFO full with a pop in the same cycle: both happen; no drop, and `level` is unchanged.
  - Pop happens when `out_valid`&&`out_ready`. `out_ready` is ignored while the FIFO is empty.
  - Push and pop in the same cycle on an empty FIFO: there is no pop, because `out_valid` was 0; the push is accepted.
- FIFO is circular with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Output order is strict FIFO.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `overflow`=0, `acc`=0, `ph`=0, both pointers 0.
- Reset mid-block discards the partial sum and all FIFO contents. Reset overrides a same-cycle `y_valid` or pop.
- Latency: on the edge where the last sample of a block is accepted, the result is written. `out_valid`=1 and `out_data`=result appear in the following cycle when the FIFO was empty.
- Throughput: one sample accepted per cycle, sustained. With `dec`=1, one result per cycle; a continuously asserted `out_ready` never stalls and never overflows.
- `level` and `out_valid` update on the same edge as the push or pop that changes them.

## Configuration
- `FIR_DECIM_ROUND_EN` defined: round half-up before the shift, r = (`s` + 2^(SHIFT−1)) >> SHIFT when SHIFT>0. With SHIFT=0 no rounding is applied. The +5 bits of accumulator headroom absorb the rounding carry.
- Not defined: plain truncation, r = `s` >> SHIFT.

## Test plan
Parameters for all scenarios: IN_W=11, OUT_W=8, SHIFT=2, DEPTH=4.
- Basic block: `dec`=4, `y_in`=100 for 4 consecutive valid cycles -> one cycle after the 4th sample, `out_valid`=1, `out_data`=100, `level`=1.
- Saturation: `dec`=4, `y_in`=2047 ×4 -> sum 8188 >> 2 = 2047 -> `out_data`=255.
- Backpressure and overflow: `out_ready`=0, `dec`=1, `y_in`=4,8,12,16,20 -> `level`=4, `overflow`=1. Then `out_ready`=1 -> outputs 1,2,3,4 in order, then `out_valid`=0 and `overflow` stays 1.
- Full with simultaneous push and pop: FIFO full, `out_ready`=1 and a final sample in the same cycle -> `level` stays 4, `overflow` stays 0.
- `dec` change mid-block: `dec`=4, two samples of 8, then `dec`=2, two more 8s -> `out_data`=8 after the 4th sample. Next two samples of 8 -> `out_data`=4.
- Reset mid-block: three samples of 100, then `rst` for 1 cycle, then four samples of 40 (`dec`=4) -> single output 40; `overflow`=0 and `level`=1.
- Rounding: `dec`=1, `y_in`=6 -> `out_data`=1 without `FIR_DECIM_ROUND_EN`, and 2 with it.

Source files
------------

// File: rtl/fir_out_decim_if.sv
// fir_out_decim_if
// Result stream leaving the decimating output stage toward the next block.
//   out_data  : FIFO head, forced to 0 while out_valid is low
//   out_valid : FIFO holds at least one result
//   out_ready : consumer takes the head this cycle
// Modports:
//   master : producer side (the decimator)
//   slave  : consumer side (downstream stage or bench)
interface fir_out_decim_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fir_out_decim.sv
// fir_out_decim
// Output stage behind the FIR filter: sums each block of `dec` unsigned
// samples, shifts the sum right by SHIFT, saturates to OUT_W bits and queues
// the result in a DEPTH-entry circular FIFO read through a valid/ready stream.
// A result arriving while the FIFO is full and nothing is being popped is
// dropped and latches the sticky `overflow` flag until reset.
//
// Optional build macro: FIR_DECIM_ROUND_EN
//   defined   : round half-up before the shift (no effect when SHIFT is 0)
//   undefined : plain truncation
//
// Ports:
//   clk      : single rising-edge clock
//   rst      : synchronous active-high reset
//   y_in     : filter output sample (IN_W bits, unsigned)
//   y_valid  : y_in valid this cycle, no backpressure toward the filter
//   dec      : decimation factor 1..15, 0 behaves as 1
//   stream   : result stream (out_data / out_valid / out_ready)
//   level    : FIFO occupancy
//   overflow : sticky drop indicator
module fir_out_decim #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          y_in,
    input  logic                     y_valid,
    input  logic [3:0]               dec,
    fir_out_decim_if.master          stream,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int PW    = $clog2(DEPTH);
    localparam int ACC_W = IN_W + 5;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
`ifdef FIR_DECIM_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W-1:0] RND = (SHIFT > 0) ? (ACC_W'(1) << RND_POS) : '0;
`endif

    logic [3:0]       ph;
    logic [3:0]       dec_l;
    logic [ACC_W-1:0] acc;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [3:0]       dec_eff;
    logic [3:0]       blk_dec;
    logic             last;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] rsum;
    logic [ACC_W-1:0] shifted;
    logic [OUT_W-1:0] result;
    logic             valid;
    logic             full;
    logic             pop;
    logic             write_en;

    // The factor of the current block comes straight from `dec` on the
    // block's first sample and from the latched copy afterwards, so a
    // mid-block change of `dec` only takes effect on the next block.
    always_comb begin
        dec_eff = (dec == 4'd0) ? 4'd1 : dec;
        blk_dec = (ph == 4'd0) ? dec_eff : dec_l;
        last    = y_valid && (ph == blk_dec - 4'd1);
        sum     = acc + ACC_W'(y_in);
`ifdef FIR_DECIM_ROUND_EN
        rsum    = sum + RND;
`else
        rsum    = sum;
`endif
        shifted = rsum >> SHIFT;
        result  = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

    // A push into a full FIFO is still accepted when the head leaves on the
    // same edge; out_ready is meaningless while the FIFO is empty.
    assign valid           = (level != '0);
    assign full            = (level == (PW+1)'(DEPTH));
    assign pop             = valid && stream.out_ready;
    assign write_en        = last && (!full || pop);
    assign stream.out_valid = valid;
    assign stream.out_data  = valid ? mem[rd_ptr] : '0;

    // Block accumulator and phase counter; the completing sample clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ph    <= 4'd0;
            dec_l <= 4'd1;
        end else if (y_valid) begin
            if (ph == 4'd0) begin
                dec_l <= dec_eff;
            end
            if (last) begin
                acc <= '0;
                ph  <= 4'd0;
            end else begin
                acc <= sum;
                ph  <= ph + 4'd1;
            end
        end
    end

    // FIFO pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (write_en && !pop) begin
                level <= level + (PW+1)'(1);
            end else if (!write_en && pop) begin
                level <= level - (PW+1)'(1);
            end
            if (last && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (write_en && !rst) begin
            mem[wr_ptr] <= result;
        end
    end
endmodule

// File: tb/tb_fir_out_decim.sv
// tb_fir_out_decim
// Self-checking bench for fir_out_decim (IN_W=11, OUT_W=8, SHIFT=2, DEPTH=4).
// Honours FIR_DECIM_ROUND_EN in its reference model when the macro is defined.
module tb_fir_out_decim;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
    localparam int SHIFT = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [10:0] y_in;
    logic        y_valid;
    logic [3:0]  dec;
    logic [2:0]  level;
    logic        overflow;

    fir_out_decim_if #(.OUT_W(OUT_W)) sif ();

    fir_out_decim #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .y_in    (y_in),
        .y_valid (y_valid),
        .dec     (dec),
        .stream  (sif.master),
        .level   (level),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: current block samples, block factor, result queue.
    int mq[$];
    int blk[$];
    int blk_dec = 1;
    bit m_ovf   = 1'b0;

    typedef struct {
        bit r;
        bit yv;
        int y;
        int d;
        bit rdy;
        bit ev;
        int ed;
        int el;
        bit eo;
    } vec_t;

    vec_t vecs[$];

    // Block sum scaled by 2^SHIFT with plain integer arithmetic, then clipped.
    function automatic int blockResult(input int vals[$]);
        int s;
        int r;
        s = 0;
        foreach (vals[i]) s += vals[i];
`ifdef FIR_DECIM_ROUND_EN
        if (SHIFT > 0) s += (1 << (SHIFT - 1));
`endif
        r = s / (1 << SHIFT);
        if (r > (1 << OUT_W) - 1) r = (1 << OUT_W) - 1;
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit pop;
        bit push;
        int res;
        push = 1'b0;
        res  = 0;
        pop  = (mq.size() > 0) && sif.out_ready;
        if (rst) begin
            mq.delete();
            blk.delete();
            m_ovf = 1'b0;
            return;
        end
        if (y_valid) begin
            if (blk.size() == 0) blk_dec = (dec == 4'd0) ? 1 : int'(dec);
            blk.push_back(int'(y_in));
            if (blk.size() == blk_dec) begin
                res  = blockResult(blk);
                push = 1'b1;
                blk.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(res);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit yv, input int y,
                                 input int d, input bit rdy);
        rst           = r;
        y_valid       = yv;
        y_in          = 11'(y);
        dec           = 4'(d);
        sif.out_ready = rdy;
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        int exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 0;
        checkValue({name, ".valid"}, int'(sif.out_valid), int'(mq.size() > 0));
        checkValue({name, ".data"}, int'(sif.out_data), exp_data);
        checkValue({name, ".level"}, int'(level), mq.size());
        checkValue({name, ".ovf"}, int'(overflow), int'(m_ovf));
    endtask

    initial begin
        int exp_round;
        int cur_dec;

        rst           = 1'b1;
        y_valid       = 1'b0;
        y_in          = '0;
        dec           = 4'd1;
        sif.out_ready = 1'b0;

        // Table: reset, basic block, saturation, backpressure with overflow.
        vecs.push_back(vec_t'{1, 0, 0,    4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 0, 0,    4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 100,  4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 100,  4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 100,  4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 100,  4, 0, 1, 100, 1, 0});
        vecs.push_back(vec_t'{0, 0, 0,    4, 1, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 2047, 4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 2047, 4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 2047, 4, 0, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 2047, 4, 0, 1, 255, 1, 0});
        vecs.push_back(vec_t'{0, 0, 0,    4, 1, 0, 0,   0, 0});
        vecs.push_back(vec_t'{0, 1, 4,    1, 0, 1, 1,   1, 0});
        vecs.push_back(vec_t'{0, 1, 8,    1, 0, 1, 1,   2, 0});
        vecs.push_back(vec_t'{0, 1, 12,   1, 0, 1, 1,   3, 0});
        vecs.push_back(vec_t'{0, 1, 16,   1, 0, 1, 1,   4, 0});
        vecs.push_back(vec_t'{0, 1, 20,   1, 0, 1, 1,   4, 1});
        vecs.push_back(vec_t'{0, 0, 0,    1, 1, 1, 2,   3, 1});
        vecs.push_back(vec_t'{0, 0, 0,    1, 1, 1, 3,   2, 1});
        vecs.push_back(vec_t'{0, 0, 0,    1, 1, 1, 4,   1, 1});
        vecs.push_back(vec_t'{0, 0, 0,    1, 1, 0, 0,   0, 1});
        vecs.push_back(vec_t'{1, 0, 0,    1, 0, 0, 0,   0, 0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].yv, vecs[i].y, vecs[i].d, vecs[i].rdy);
            checkValue($sformatf("vec%0d.valid", i), int'(sif.out_valid), int'(vecs[i].ev));
            checkValue($sformatf("vec%0d.data", i), int'(sif.out_data), vecs[i].ed);
            checkValue($sformatf("vec%0d.level", i), int'(level), vecs[i].el);
            checkValue($sformatf("vec%0d.ovf", i), int'(overflow), int'(vecs[i].eo));
        end

        // Full FIFO with a push and a pop on the same edge.
        applyStimulus(1, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 4 * k, 1, 0);
            checkOutput("fill");
        end
        checkValue("full_level", int'(level), 4);
        applyStimulus(0, 1, 40, 1, 1);
        checkValue("pushpop_level", int'(level), 4);
        checkValue("pushpop_ovf", int'(overflow), 0);
        checkValue("pushpop_head", int'(sif.out_data), 2);
        checkOutput("pushpop");

        // Decimation factor changed in the middle of a block.
        applyStimulus(1, 0, 0, 4, 0);
        applyStimulus(0, 1, 8, 4, 1);
        applyStimulus(0, 1, 8, 4, 1);
        applyStimulus(0, 1, 8, 2, 1);
        checkValue("decchg_wait", int'(sif.out_valid), 0);
        applyStimulus(0, 1, 8, 2, 1);
        checkValue("decchg_first", int'(sif.out_data), 8);
        checkOutput("decchg1");
        applyStimulus(0, 1, 8, 2, 1);
        checkOutput("decchg2");
        applyStimulus(0, 1, 8, 2, 1);
        checkValue("decchg_second", int'(sif.out_data), 4);
        checkOutput("decchg3");

        // Reset in the middle of a block discards the partial sum.
        applyStimulus(0, 0, 0, 4, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 100, 4, 0);
        applyStimulus(1, 0, 0, 4, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 40, 4, 0);
        checkValue("rstmid_data", int'(sif.out_data), 40);
        checkValue("rstmid_level", int'(level), 1);
        checkValue("rstmid_ovf", int'(overflow), 0);

        // Rounding behaviour of a single small sample.
`ifdef FIR_DECIM_ROUND_EN
        exp_round = 2;
`else
        exp_round = 1;
`endif
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 1, 6, 1, 0);
        checkValue("round", int'(sif.out_data), exp_round);
        checkOutput("round");

        // Randomized traffic against the reference model.
        cur_dec = 3;
        for (int n = 0; n < 1500; n++) begin
            bit r;
            bit yv;
            bit rdy;
            int y;
            if ($urandom_range(0, 39) == 0) cur_dec = $urandom_range(0, 15);
            r   = ($urandom_range(0, 199) == 0);
            yv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            y   = ($urandom_range(0, 7) == 0) ? 2047 : $urandom_range(0, 2047);
            applyStimulus(r, yv, y, cur_dec, rdy);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
